wb_stage_pipe: RTL and testbench
================================

Name: wb_stage_pipe

Overview:
- Parametrised, registered successor to the combinational RV writeback stage.
- Selects the writeback source: ALU, aligned load data, or PC+4.
- Supports variable-latency loads through a data-memory response handshake. While waiting, it stalls the upstream pipeline and bounds the wait with a timeout.
- Drives the register-file write port and a debug/retire interface. Sits between the MEM stage and the regfile.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- OFFW, 2, byte-offset width; must equal log2(XLEN/8).
- LD_TIMEOUT, 255, max cycles spent in WAIT_LD before a forced completion; must be ≥1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_wb_valid  in  1  MEM stage presents an instruction this cycle
- i_wb_sel  in  2  source select: 00 ALU, 01 load, 10 ALU, 11 PC+4
- i_rd_addr  in  5  destination register
- i_rd_wren  in  1  instruction writes rd
- i_alu_data  in  XLEN  ALU result
- i_pc  in  XLEN  instruction PC
- i_ld_funct3  in  3  load type (RV funct3)
- i_ld_addr_lsb  in  OFFW  load byte offset
- i_ld_rvalid  in  1  load response valid
- i_ld_rdata  in  XLEN  raw load word
- o_stall  out  1  hold MEM stage and earlier stages
- o_rd_wren  out  1  regfile write enable, registered
- o_rd_addr  out  5  regfile write address, registered
- o_rd_data  out  XLEN  regfile write data, registered
- o_insn_vld  out  1  one-cycle retire pulse
- o_pc_debug  out  XLEN  PC of the retired instruction
- o_ld_err  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - All registered outputs, the timeout counter and the capture registers are cleared to 0.
  - o_stall reads 0.
- States:
  - IDLE:
    - i_wb_valid=1 with sel≠01, or with sel=01 and i_ld_rvalid=1: outputs update at the next edge (latency 1).
    - i_wb_valid=1, sel=01, i_ld_rvalid=0: capture rd_addr, rd_wren, pc, funct3 and lsb; clear the counter; go to WAIT_LD.
    - In the same cycle, o_stall=1 combinationally.
  - WAIT_LD:
    - o_stall = ~i_ld_rvalid.
    - i_wb_valid is ignored.
    - The counter increments each cycle.
    - On i_ld_rvalid=1: write the aligned captured load at the next edge, then go to IDLE.
    - Counter reaching LD_TIMEOUT with no rvalid: write 0, pulse o_ld_err with o_insn_vld, go to IDLE, deassert o_stall.
    - rvalid in the same cycle as the timeout: rvalid wins and o_ld_err stays 0.
- Write data:
  - sel 00/10: alu_data.
  - sel 11: pc+4, modulo 2^XLEN (wraps).
  - sel 01: aligned load.
- Load alignment:
  - LB/LBU (000/100): byte at offset lsb, sign- or zero-extended.
  - LH/LHU (001/101): halfword at offset {lsb[OFFW-1:1],0}, sign- or zero-extended. A misaligned lsb[0] is ignored.
  - LW (010): word at offset {lsb[OFFW-1:2],00}. Sign-extended when XLEN=64.
  - LWU (110) and LD (011): honoured only when XLEN=64. When XLEN=32 they are treated as LW.
  - 111: treated as LW.
- Write enable: o_rd_wren = valid & rd_wren & (rd_addr≠0). An rd of x0 is never written, but o_insn_vld still pulses.
- Retire outputs: o_insn_vld and o_pc_debug update on the same edge as o_rd_*. With no retire, o_insn_vld=0 and o_rd_wren=0; o_rd_addr, o_rd_data and o_pc_debug hold their values.
- Stray i_ld_rvalid in IDLE with no pending load: ignored.
- Reset asserted mid-WAIT_LD: the pending load is abandoned and no write occurs.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: adds output o_retire_cnt [63:0].
  - Reset to 0.
  - Increments on every o_insn_vld pulse, including timeouts.
  - Wraps to 0 after all-ones.
- Undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
- ALU path: valid, sel=00, rd=5, alu=0x1234 → next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0x1234, o_insn_vld=1, o_stall never 1.
- PC+4 with wrap: sel=11, pc=0xFFFFFFFC, rd=1 → o_rd_data=0x00000000.
- Load alignment:
  - rdata=0x80FF7F01, LB lsb=1 → 0x0000007F.
  - LB lsb=3 → 0xFFFFFF80.
  - LHU lsb=2 → 0x000080FF.
  - LH lsb=3 → 0xFFFF80FF.
- Delayed load: sel=01, rvalid low for 3 cycles, rdata=0xDEADBEEF on cycle 4, LW rd=7 → o_stall=1 for 3 cycles, 0 in the rvalid cycle; write of 0xDEADBEEF to rd 7 one cycle later. A new i_wb_valid during the wait is ignored.
- Timeout: LD_TIMEOUT=4, rvalid never → o_ld_err=1 and o_insn_vld=1 together, o_rd_data=0, o_stall drops. Repeat with rvalid on the exact timeout cycle → o_ld_err=0.
- x0 and reset:
  - rd=0, alu=0x55 → o_rd_wren=0, o_insn_vld=1.
  - Assert i_rst_n=0 mid-WAIT_LD → all outputs 0 immediately; no write after release.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Registered RV writeback stage with variable-latency load wait and timeout.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int OFFW       = 2,
  parameter int LD_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_wb_valid,
  input  logic [1:0]      i_wb_sel,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_wren,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_ld_funct3,
  input  logic [OFFW-1:0] i_ld_addr_lsb,
  input  logic            i_ld_rvalid,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic            o_stall,
  output logic            o_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_insn_vld,
  output logic [XLEN-1:0] o_pc_debug,
  output logic            o_ld_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     o_retire_cnt
`endif
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WAIT_LD = 1'b1;
  localparam int CW = $clog2(LD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LD_TIMEOUT - 1);

  logic [0:0]      st;
  logic [CW-1:0]   cnt;
  logic [4:0]      cap_rd;
  logic            cap_wren;
  logic [XLEN-1:0] cap_pc;
  logic [2:0]      cap_f3;
  logic [OFFW-1:0] cap_lsb;

  logic            retire;
  logic            go_wait;
  logic            tmo;
  logic [4:0]      n_addr;
  logic            n_wren;
  logic [XLEN-1:0] n_pc;
  logic [XLEN-1:0] n_data;

  // Shift the addressed lane down to bit 0, then extend by load type.
  function automatic logic [XLEN-1:0] align(
    input logic [XLEN-1:0] w,
    input logic [2:0]      f3,
    input logic [OFFW-1:0] lsb
  );
    logic [OFFW-1:0]    off;
    logic [XLEN-1:0]    sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    logic signed [31:0] sw;
    case (f3)
      3'b000, 3'b100: off = lsb;
      3'b001, 3'b101: off = lsb & ~OFFW'(1);
      3'b011: off = (XLEN == 64) ? '0 : (lsb & ~OFFW'(3));
      default: off = lsb & ~OFFW'(3);
    endcase
    sh  = w >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    sw  = sh[31:0];
    case (f3)
      3'b000: align = XLEN'(sb);
      3'b100: align = XLEN'(sh[7:0]);
      3'b001: align = XLEN'(shw);
      3'b101: align = XLEN'(sh[15:0]);
      3'b110: align = XLEN'(sh[31:0]);
      3'b011: align = (XLEN == 64) ? sh : XLEN'(sw);
      default: align = XLEN'(sw);
    endcase
  endfunction

  always_comb begin
    o_stall = 1'b0;
    retire  = 1'b0;
    go_wait = 1'b0;
    tmo     = 1'b0;
    n_addr  = i_rd_addr;
    n_wren  = i_rd_wren;
    n_pc    = i_pc;
    n_data  = i_alu_data;
    unique case (1'b1)
      st == IDLE: begin
        if (i_wb_valid) begin
          if (i_wb_sel == 2'b01 && !i_ld_rvalid) begin
            go_wait = 1'b1;
            o_stall = 1'b1;
          end else begin
            retire = 1'b1;
          end
        end
        unique case (i_wb_sel)
          2'b01: n_data = align(i_ld_rdata, i_ld_funct3,
                                i_ld_addr_lsb);
          2'b11: n_data = i_pc + XLEN'(4);
          default: n_data = i_alu_data;
        endcase
      end
      default: begin
        n_addr = cap_rd;
        n_wren = cap_wren;
        n_pc   = cap_pc;
        // rvalid takes priority over an expiring timeout
        if (i_ld_rvalid) begin
          retire = 1'b1;
          n_data = align(i_ld_rdata, cap_f3, cap_lsb);
        end else if (cnt == CNT_LAST) begin
          retire = 1'b1;
          tmo    = 1'b1;
          n_data = '0;
        end else begin
          o_stall = 1'b1;
          n_data  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st       <= IDLE;
      cnt      <= '0;
      cap_rd   <= '0;
      cap_wren <= 1'b0;
      cap_pc   <= '0;
      cap_f3   <= '0;
      cap_lsb  <= '0;
    end else begin
      if (go_wait) begin
        st       <= WAIT_LD;
        cnt      <= '0;
        cap_rd   <= i_rd_addr;
        cap_wren <= i_rd_wren;
        cap_pc   <= i_pc;
        cap_f3   <= i_ld_funct3;
        cap_lsb  <= i_ld_addr_lsb;
      end else if (st == WAIT_LD) begin
        if (retire) begin
          st  <= IDLE;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_wren  <= 1'b0;
      o_rd_addr  <= '0;
      o_rd_data  <= '0;
      o_insn_vld <= 1'b0;
      o_pc_debug <= '0;
      o_ld_err   <= 1'b0;
    end else begin
      o_rd_wren  <= retire & n_wren & (n_addr != 5'd0);
      o_insn_vld <= retire;
      o_ld_err   <= tmo;
      if (retire) begin
        o_rd_addr  <= n_addr;
        o_rd_data  <= n_data;
        o_pc_debug <= n_pc;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_retire_cnt <= '0;
    end else if (o_insn_vld) begin
      o_retire_cnt <= o_retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: vector table plus multi-cycle sequences.
// Runs with XLEN=32 and LD_TIMEOUT=4.
module tb_wb_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_addr;
  logic        rd_wren;
  logic [31:0] alu_data;
  logic [31:0] pc;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_lsb;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        stall;
  logic        o_wren;
  logic [4:0]  o_addr;
  logic [31:0] o_data;
  logic        insn_vld;
  logic [31:0] pc_debug;
  logic        ld_err;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int n_chk;
  int n_fail;

  wb_stage_pipe #(
    .XLEN(32),
    .OFFW(2),
    .LD_TIMEOUT(4)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_wb_valid(wb_valid),
    .i_wb_sel(wb_sel),
    .i_rd_addr(rd_addr),
    .i_rd_wren(rd_wren),
    .i_alu_data(alu_data),
    .i_pc(pc),
    .i_ld_funct3(ld_funct3),
    .i_ld_addr_lsb(ld_lsb),
    .i_ld_rvalid(ld_rvalid),
    .i_ld_rdata(ld_rdata),
    .o_stall(stall),
    .o_rd_wren(o_wren),
    .o_rd_addr(o_addr),
    .o_rd_data(o_data),
    .o_insn_vld(insn_vld),
    .o_pc_debug(pc_debug),
    .o_ld_err(ld_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .o_retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        wren;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [31:0] rdata;
    logic        exp_wren;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [4:0] rd,
                            input logic [31:0] p);
    wb_valid  = 1'b1;
    wb_sel    = 2'b01;
    rd_addr   = rd;
    rd_wren   = 1'b1;
    pc        = p;
    ld_funct3 = 3'b010;
    ld_lsb    = 2'd0;
    ld_rvalid = 1'b0;
    #1;
    check("ld_issue_stall", stall, 1);
    tick();
    check("ld_issue_vld", insn_vld, 0);
    wb_valid = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vt[0]  = '{2'b00, 5'd5, 1'b1, 32'h1234, 32'h40,
               3'b010, 2'd0, 32'h0, 1'b1, 32'h1234};
    vt[1]  = '{2'b11, 5'd1, 1'b1, 32'h0, 32'hFFFFFFFC,
               3'b010, 2'd0, 32'h0, 1'b1, 32'h0};
    vt[2]  = '{2'b10, 5'd3, 1'b1, 32'hCAFE0000, 32'h48,
               3'b010, 2'd0, 32'h0, 1'b1, 32'hCAFE0000};
    vt[3]  = '{2'b01, 5'd2, 1'b1, 32'h0, 32'h4C,
               3'b000, 2'd1, 32'h80FF7F01, 1'b1, 32'h7F};
    vt[4]  = '{2'b01, 5'd2, 1'b1, 32'h0, 32'h50,
               3'b000, 2'd3, 32'h80FF7F01, 1'b1, 32'hFFFFFF80};
    vt[5]  = '{2'b01, 5'd4, 1'b1, 32'h0, 32'h54,
               3'b101, 2'd2, 32'h80FF7F01, 1'b1, 32'h000080FF};
    vt[6]  = '{2'b01, 5'd4, 1'b1, 32'h0, 32'h58,
               3'b001, 2'd3, 32'h80FF7F01, 1'b1, 32'hFFFF80FF};
    vt[7]  = '{2'b01, 5'd6, 1'b1, 32'h0, 32'h5C,
               3'b100, 2'd3, 32'h80FF7F01, 1'b1, 32'h00000080};
    vt[8]  = '{2'b01, 5'd6, 1'b1, 32'h0, 32'h60,
               3'b010, 2'd2, 32'h80FF7F01, 1'b1, 32'h80FF7F01};
    vt[9]  = '{2'b01, 5'd6, 1'b1, 32'h0, 32'h64,
               3'b011, 2'd1, 32'h80FF7F01, 1'b1, 32'h80FF7F01};
    vt[10] = '{2'b01, 5'd9, 1'b1, 32'h0, 32'h68,
               3'b001, 2'd0, 32'h80FF7F01, 1'b1, 32'h00007F01};
    vt[11] = '{2'b00, 5'd9, 1'b0, 32'h77, 32'h6C,
               3'b010, 2'd0, 32'h0, 1'b0, 32'h77};
    vt[12] = '{2'b00, 5'd0, 1'b1, 32'h55, 32'h70,
               3'b010, 2'd0, 32'h0, 1'b0, 32'h55};

    rst_n     = 1'b0;
    wb_valid  = 1'b0;
    wb_sel    = 2'b00;
    rd_addr   = 5'd0;
    rd_wren   = 1'b0;
    alu_data  = 32'h0;
    pc        = 32'h0;
    ld_funct3 = 3'b000;
    ld_lsb    = 2'd0;
    ld_rvalid = 1'b0;
    ld_rdata  = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_wren", o_wren, 0);
    check("rst_addr", o_addr, 0);
    check("rst_data", o_data, 0);
    check("rst_vld", insn_vld, 0);
    check("rst_pc", pc_debug, 0);
    check("rst_err", ld_err, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      wb_valid  = 1'b1;
      wb_sel    = vt[i].sel;
      rd_addr   = vt[i].rd;
      rd_wren   = vt[i].wren;
      alu_data  = vt[i].alu;
      pc        = vt[i].pc;
      ld_funct3 = vt[i].f3;
      ld_lsb    = vt[i].lsb;
      ld_rdata  = vt[i].rdata;
      ld_rvalid = 1'b1;
      #1;
      check($sformatf("v%0d_stall", i), stall, 0);
      tick();
      check($sformatf("v%0d_wren", i), o_wren, vt[i].exp_wren);
      check($sformatf("v%0d_addr", i), o_addr, vt[i].rd);
      check($sformatf("v%0d_data", i), o_data, vt[i].exp_data);
      check($sformatf("v%0d_vld", i), insn_vld, 1);
      check($sformatf("v%0d_pc", i), pc_debug, vt[i].pc);
      check($sformatf("v%0d_err", i), ld_err, 0);
    end

    wb_valid  = 1'b0;
    wb_sel    = 2'b01;
    ld_rvalid = 1'b1;
    ld_rdata  = 32'hFFFFFFFF;
    #1;
    check("idle_stall", stall, 0);
    tick();
    check("hold_vld", insn_vld, 0);
    check("hold_wren", o_wren, 0);
    check("hold_data", o_data, 32'h55);
    check("hold_addr", o_addr, 0);
    check("hold_pc", pc_debug, 32'h70);

    issue_load(5'd7, 32'h200);
    for (int k = 0; k < 2; k++) begin
      wb_valid = 1'b1;
      wb_sel   = 2'b00;
      rd_addr  = 5'd12;
      alu_data = 32'h999;
      pc       = 32'h204;
      #1;
      check("dly_stall", stall, 1);
      tick();
      check("dly_ignore_vld", insn_vld, 0);
    end
    wb_valid  = 1'b0;
    ld_rvalid = 1'b1;
    ld_rdata  = 32'hDEADBEEF;
    #1;
    check("dly_rvalid_stall", stall, 0);
    tick();
    ld_rvalid = 1'b0;
    check("dly_wren", o_wren, 1);
    check("dly_addr", o_addr, 7);
    check("dly_data", o_data, 32'hDEADBEEF);
    check("dly_vld", insn_vld, 1);
    check("dly_pc", pc_debug, 32'h200);
    tick();
    check("dly_after_vld", insn_vld, 0);

    issue_load(5'd8, 32'h300);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("tmo_stall", stall, 1);
      tick();
      check("tmo_wait_vld", insn_vld, 0);
      check("tmo_wait_err", ld_err, 0);
    end
    tick();
    check("tmo_err", ld_err, 1);
    check("tmo_vld", insn_vld, 1);
    check("tmo_data", o_data, 0);
    check("tmo_addr", o_addr, 8);
    check("tmo_pc", pc_debug, 32'h300);
    check("tmo_stall_drop", stall, 0);
    tick();
    check("tmo_err_pulse", ld_err, 0);
    check("tmo_vld_pulse", insn_vld, 0);

    issue_load(5'd11, 32'h380);
    for (int k = 0; k < 3; k++) tick();
    ld_rvalid = 1'b1;
    ld_rdata  = 32'h12345678;
    tick();
    ld_rvalid = 1'b0;
    check("race_err", ld_err, 0);
    check("race_vld", insn_vld, 1);
    check("race_data", o_data, 32'h12345678);
    check("race_addr", o_addr, 11);

    issue_load(5'd10, 32'h400);
    rst_n = 1'b0;
    #1;
    check("mrst_wren", o_wren, 0);
    check("mrst_addr", o_addr, 0);
    check("mrst_data", o_data, 0);
    check("mrst_vld", insn_vld, 0);
    check("mrst_pc", pc_debug, 0);
    check("mrst_err", ld_err, 0);
    check("mrst_stall", stall, 0);
    ld_rvalid = 1'b1;
    ld_rdata  = 32'hAAAA5555;
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst_post_vld", insn_vld, 0);
    check("mrst_post_wren", o_wren, 0);
    check("mrst_post_data", o_data, 0);
    tick();
    ld_rvalid = 1'b0;
    check("mrst_post2_vld", insn_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
